alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width in bits.
REQ-002 Port: clk  input  1  rising-edge clock, single clock domain.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-005 Port: req_ready  output  2  per-requester acceptance; a request transfers when req_valid[i] & req_ready[i] on a clock edge.
REQ-006 Port: a0, b0 / a1, b1  input  WIDTH each  operands of requester 0 / 1.
REQ-007 Port: sel0 / sel1  input  4 each  opcode of requester 0 / 1.
REQ-008 Port: res  output  WIDTH  registered result.
REQ-009 Port: res_valid  output  1  result valid.
REQ-010 Port: res_id  output  1  index of the requester owning res.
REQ-011 Port: res_ready  input  1  result consumer acceptance; result retires on res_valid & res_ready.

Function
REQ-012 Opcode map: 0000 A+B; 0001 A-B; 0010 AND; 0011 OR; 0100 XOR; 0101 A==B; 0110 A>B unsigned; 0111 A<<B; 1000 A>>B logical; all other opcodes give 0.
REQ-013 Add/subtract wrap modulo 2^WIDTH; carry/borrow discarded.
REQ-014 Comparisons give 1 (zero-extended to WIDTH) when true, else 0.
REQ-015 Shifts use B as an unsigned amount; an amount >= WIDTH gives 0.
REQ-016 FSM states: IDLE, EXEC, DONE.
REQ-017 IDLE: req_ready = one-hot grant to the winner when any req_valid is set, else 0; on transfer, latch a/b/sel of the winner plus its index, then go to EXEC.
REQ-018 EXEC: req_ready = 0; compute the ALU result from the latched operands and register it into res; set res_valid = 1 and res_id = latched index; go to DONE.
REQ-019 DONE: req_ready = 0; res, res_id and res_valid hold stable until res_ready = 1; on retire, clear res_valid and go to IDLE.
REQ-020 Latency: result valid 2 cycles after the grant edge; minimum throughput is one operation per 3 cycles when res_ready is held high.
REQ-021 Arbitration is round-robin: with a single requester valid, that requester wins; with both valid, the requester not granted last wins.
REQ-022 The last-granted pointer updates only on a transfer.
REQ-023 req_ready is a combinational function of state, req_valid and the pointer only; it never depends on res_ready.
REQ-024 Operand or valid changes after the grant edge do not affect the in-flight result.
REQ-025 A requester may drop req_valid before it is granted; no request is then recorded for it.

Reset
REQ-026 On rst_n = 0, immediately: state = IDLE, res = 0, res_valid = 0, res_id = 0, last-granted pointer = 1 (requester 0 wins the first tie).
REQ-027 Reset asserted in EXEC or DONE aborts the operation; no result is delivered for it after reset release.
REQ-028 req_ready = 0 while rst_n = 0.
REQ-029 The first grant is possible on the first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro ALU_ARBITER_ZFLAG_EN defined: adds output res_zero (1 bit), registered with res, equal to 1 when res == 0; reset value 0; held in DONE like res.
REQ-031 Macro ALU_ARBITER_ZFLAG_EN undefined: res_zero port absent; all other behaviour is identical.

Verification
REQ-032 Single request: req_valid=01, a0=7, b0=5, sel0=0000, res_ready=1 -> req_ready=01 at grant, res=12 (0xC), res_id=0, res_valid high exactly 1 cycle, 2 cycles after grant.
REQ-033 Tie rotation: req_valid=11 held; requester 0 a=3,b=5,sel=0001; requester 1 a=9,b=9,sel=0101 -> grants alternate 0,1,0; results 14 (0xE, id 0) then 1 (id 1).
REQ-034 Backpressure: res_ready=0 for 5 cycles in DONE with a0=4'b1010, b0=4'b0110, sel0=0100 -> res=1100, res_id and res_valid stable, req_ready=00 throughout; retires on the cycle res_ready=1.
REQ-035 Boundaries: sel=0111 with a=0001, b=4 -> 0; sel=1000 with a=1000, b=3 -> 0001; sel=0110 with a=2, b=2 -> 0; sel=1111 -> 0; sel=0000 with a=15, b=1 -> 0.
REQ-036 Reset mid-operation: assert rst_n=0 during EXEC -> res_valid=0 immediately; after release, requester 0 wins a tie and no stale result appears.
REQ-037 With ALU_ARBITER_ZFLAG_EN: a=6, b=6, sel=0001 -> res=0, res_zero=1; a=6, b=5, sel=0001 -> res=1, res_zero=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a small multi-cycle ALU (IDLE -> EXEC -> DONE).
// Optional zero flag output res_zero is enabled by defining ALU_ARBITER_ZFLAG_EN.
module alu_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [3:0]       sel0,
  input  logic [3:0]       sel1,
  output logic [WIDTH-1:0] res,
  output logic             res_valid,
  output logic             res_id,
`ifdef ALU_ARBITER_ZFLAG_EN
  output logic             res_zero,
`endif
  input  logic             res_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic logic [WIDTH-1:0] alu_op(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [3:0]       sel);
    logic [WIDTH-1:0] r;
    r = '0;
    case (sel)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0010: r = a & b;
      4'b0011: r = a | b;
      4'b0100: r = a ^ b;
      4'b0101: r = WIDTH'(a == b);
      4'b0110: r = WIDTH'(a > b);
      4'b0111: begin
        if (32'(b) >= 32'(WIDTH)) r = '0;
        else                      r = a << b;
      end
      4'b1000: begin
        if (32'(b) >= 32'(WIDTH)) r = '0;
        else                      r = a >> b;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       sel_q, sel_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             res_valid_q, res_valid_d;
  logic             res_id_q, res_id_d;
  logic             win_s;
  logic [1:0]       grant_s;
  logic             xfer_s;
  logic [WIDTH-1:0] alu_res_s;

  // Round-robin winner and IDLE-only grant; held off while reset is asserted
  always_comb begin
    win_s   = 1'b0;
    grant_s = 2'b00;
    if (req_valid == 2'b11)      win_s = ~last_q;
    else if (req_valid == 2'b10) win_s = 1'b1;
    else                         win_s = 1'b0;
    if (rst_n && (state_q == IDLE) && (req_valid != 2'b00)) grant_s = win_s ? 2'b10 : 2'b01;
    else                                                    grant_s = 2'b00;
  end

  assign req_ready = grant_s;
  assign xfer_s    = |(req_valid & grant_s);
  assign alu_res_s = alu_op(a_q, b_q, sel_q);

  // Next-state and datapath capture for the three-phase operation
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    case (state_q)
      IDLE: begin
        if (xfer_s) begin
          state_d = EXEC;
          last_d  = win_s;
          id_d    = win_s;
          a_d     = win_s ? a1 : a0;
          b_d     = win_s ? b1 : b0;
          sel_d   = win_s ? sel1 : sel0;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        res_d       = alu_res_s;
        res_valid_d = 1'b1;
        res_id_d    = id_q;
        state_d     = DONE;
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State, operand latch and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= 4'b0000;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
    end
  end

  assign res       = res_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;

`ifdef ALU_ARBITER_ZFLAG_EN
  logic zero_q, zero_d;

  // Zero flag captured alongside the result
  always_comb begin
    zero_d = zero_q;
    if (state_q == EXEC) zero_d = (alu_res_s == '0);
    else                 zero_d = zero_q;
  end

  // Zero flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) zero_q <= 1'b0;
    else        zero_q <= zero_d;
  end

  assign res_zero = zero_q;
`endif

endmodule
